sopc_2_motor_sense: RTL

SOPC_2_MOTOR_SENSE -- requirements
Module: sopc_2_motor_sense

---
 rtl/sopc_2_motor_sense.sv | 104 ++++++++++
 1 files changed

// File: rtl/sopc_2_motor_sense.sv
// Motor sense input port: 2-flop synchronizer, optional per-bit debounce,
// edge capture with irq mask, Avalon-MM slave. Debounce built in with SOPC_2_MOTOR_SENSE_DEBOUNCE_EN.
module sopc_2_motor_sense #(
  parameter int WIDTH           = 14,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync1, sync2, filt, prev;
  logic [WIDTH-1:0] irqmask, edgecapture, detect, clr;
  logic             wr_en;
  logic             unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign unused_wdata = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
      prev  <= filt;
    end
  end

`ifdef SOPC_2_MOTOR_SENSE_DEBOUNCE_EN
  localparam logic [15:0] CNT_MAX = 16'(DEBOUNCE_CYCLES - 1);

  // filt[i] follows sync2[i] only after DEBOUNCE_CYCLES consecutive differing cycles.
  for (genvar i = 0; i < WIDTH; i++) begin : g_deb
    logic [15:0] cnt;
    logic        filt_bit;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt      <= '0;
        filt_bit <= 1'b0;
      end else if (sync2[i] == filt_bit) begin
        cnt <= '0;
      end else if (cnt >= CNT_MAX) begin
        filt_bit <= sync2[i];
        cnt      <= '0;
      end else begin
        cnt <= cnt + 16'd1;
      end
    end

    assign filt[i] = filt_bit;
  end
`else
  assign filt = sync2;
`endif

  always_comb begin
    detect = '0;
    case (EDGE_TYPE)
      1:       detect = ~filt & prev;
      2:       detect = filt ^ prev;
      default: detect = filt & ~prev;
    endcase
  end

  always_comb begin
    clr = '0;
    if (wr_en && address == 2'd2) clr = writedata[WIDTH-1:0];
  end

  // New edges win over a same-cycle write-1-to-clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask     <= '0;
      edgecapture <= '0;
    end else begin
      if (wr_en && address == 2'd1) irqmask <= writedata[WIDTH-1:0];
      edgecapture <= (edgecapture & ~clr) | detect;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata[WIDTH-1:0] = filt;
      2'd1:    readdata[WIDTH-1:0] = irqmask;
      2'd2:    readdata[WIDTH-1:0] = edgecapture;
      default: readdata = '0;
    endcase
  end

  assign irq = |(edgecapture & irqmask);

endmodule
